// File: rtl/mvm_result_stage.sv
// mvm_result_stage
//   Captures each accumulated y row from the MVM controller (wr_en_y pulse),
//   converts it to DATA_WIDTH, and queues it in a show-ahead FIFO drained by a
//   valid/ready stream. The controller never stalls: a push into a full FIFO
//   (with no pop that cycle) is dropped and flagged in sticky overflow.
//
//   Build option: define MVM_RESULT_SAT_EN to saturate y_in to the signed
//   DATA_WIDTH range; otherwise y_in is wrap-truncated to its low bits.
//
// Ports
//   clk, reset     clock, synchronous active-high reset
//   start          new vector: row index back to 0
//   wr_en_y, y_in  one row of signed accumulator result
//   m_valid/m_ready/m_data/m_row/m_last  output stream (head of FIFO)
//   level          occupied FIFO entries (registered)
//   overflow       sticky: row dropped on full FIFO
//   short_vec      sticky: start arrived mid-vector
//   clr_err        clears sticky flags (a same-cycle set wins)
module mvm_result_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_ROWS   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          wr_en_y,
  input  logic [ACC_WIDTH-1:0]          y_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [$clog2(NUM_ROWS)-1:0]   m_row,
  output logic                          m_last,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          short_vec,
  input  logic                          clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t               mem [FIFO_DEPTH];
  entry_t               head;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [RW-1:0]        row_idx, cur_row;
  logic [DATA_WIDTH-1:0] conv;
  logic                 full, empty, pop, push, drop;

  // ---------------------------------------------------------------- convert
`ifdef MVM_RESULT_SAT_EN
  // In range exactly when all bits from the DATA_WIDTH sign bit upward agree.
  logic [ACC_WIDTH-DATA_WIDTH:0] hi;
  assign hi = y_in[ACC_WIDTH-1:DATA_WIDTH-1];
  always_comb begin
    conv = y_in[DATA_WIDTH-1:0];
    if (hi != '0 && hi != '1)
      conv = y_in[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^y_in[ACC_WIDTH-1:DATA_WIDTH];
  assign conv      = y_in[DATA_WIDTH-1:0];
`endif

  // ---------------------------------------------------------------- control
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && m_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push    = wr_en_y && (!full || pop);
  assign drop    = wr_en_y && full && !pop;
  // start in the same cycle as a push tags that row as row 0.
  assign cur_row = start ? '0 : row_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      row_idx   <= '0;
      overflow  <= 1'b0;
      short_vec <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);

      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      // Dropped rows still advance the index so later rows stay aligned.
      if (wr_en_y)
        row_idx <= (cur_row == RW'(NUM_ROWS-1)) ? '0 : cur_row + RW'(1);
      else if (start)
        row_idx <= '0;

      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;

      if (start && row_idx != '0) short_vec <= 1'b1;
      else if (clr_err)           short_vec <= 1'b0;
    end
  end

  // Storage is not reset; outputs are gated by m_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{row: cur_row, data: conv};
  end

  // ---------------------------------------------------------------- output
  assign head    = mem[rd_ptr[AW-1:0]];
  assign m_valid = !empty;
  assign m_data  = m_valid ? head.data : '0;
  assign m_row   = m_valid ? head.row  : '0;
  assign m_last  = m_valid && (head.row == RW'(NUM_ROWS-1));

endmodule

// File: tb/tb_mvm_result_stage.sv
// Bench for mvm_result_stage: table-driven vectors, hand sequences for the
// multi-cycle corner cases, then randomized traffic against a queue model.
module tb_mvm_result_stage;
  localparam int DW = 16, AW = 32, NR = 3, FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0, start = 1'b0, wr_en_y = 1'b0, m_ready = 1'b0, clr_err = 1'b0;
  logic [AW-1:0] y_in = '0;
  logic          m_valid, m_last, overflow, short_vec;
  logic [DW-1:0] m_data;
  logic [1:0]    m_row;
  logic [2:0]    level;

  int checks = 0, errors = 0;

  mvm_result_stage #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_ROWS(NR), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .wr_en_y(wr_en_y), .y_in(y_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_last(m_last), .level(level), .overflow(overflow), .short_vec(short_vec),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------ model
  typedef struct { int row; logic [DW-1:0] data; } ent_t;
  ent_t q[$];
  int   m_ridx = 0;
  bit   m_ov = 0, m_sv = 0;

  function automatic logic [DW-1:0] conv(input logic [AW-1:0] y);
    longint v;
    v = longint'($signed(y));
`ifdef MVM_RESULT_SAT_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return y[DW-1:0];
  endfunction

  task automatic model_edge();
    bit pop, full;
    int row, old_ridx;
    if (reset) begin
      q.delete(); m_ridx = 0; m_ov = 0; m_sv = 0;
      return;
    end
    pop = (q.size() > 0) && m_ready;
    full = (q.size() == FD);
    old_ridx = m_ridx;
    row = start ? 0 : m_ridx;
    if (pop) void'(q.pop_front());
    if (wr_en_y) begin
      if (full && !pop) m_ov = 1;
      else begin
        ent_t e;
        e.row = row; e.data = conv(y_in);
        q.push_back(e);
      end
      m_ridx = (row + 1) % NR;
    end else if (start) m_ridx = 0;
    if (wr_en_y && full && !pop) m_ov = 1;
    else if (clr_err)            m_ov = 0;
    if (start && old_ridx != 0)  m_sv = 1;
    else if (clr_err)            m_sv = 0;
  endtask

  // ------------------------------------------------------------ checks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("model.m_valid", 32'(m_valid), 32'(q.size() > 0));
    chk("model.level", 32'(level), 32'(q.size()));
    chk("model.overflow", 32'(overflow), 32'(m_ov));
    chk("model.short_vec", 32'(short_vec), 32'(m_sv));
    if (q.size() > 0) begin
      chk("model.m_data", 32'(m_data), 32'(q[0].data));
      chk("model.m_row", 32'(m_row), 32'(q[0].row));
      chk("model.m_last", 32'(m_last), 32'(q[0].row == NR - 1));
    end
  endtask

  // Drive inputs, take one clock edge, update the model, compare on negedge.
  task automatic step(input bit rs, input bit st, input bit wr,
                      input logic [AW-1:0] y, input bit rdy, input bit cl);
    reset = rs; start = st; wr_en_y = wr; y_in = y; m_ready = rdy; clr_err = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_model();
  endtask

  task automatic idle(input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, rdy, 0);
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    logic [AW-1:0] y;
    logic [DW-1:0] data;
    int            row;
    bit            last;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{32'd5,          16'h0005, 0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFD,  16'hFFFD, 1, 1'b0};
    tbl[2] = '{32'd100,        16'h0064, 2, 1'b1};
`ifdef MVM_RESULT_SAT_EN
    tbl[3] = '{32'h0001_0000,  16'h7FFF, 0, 1'b0};
    tbl[4] = '{32'hFFFE_0000,  16'h8000, 1, 1'b0};
    tbl[5] = '{32'hFFFF_7FFF,  16'h8000, 2, 1'b1};
`else
    tbl[3] = '{32'h0001_0000,  16'h0000, 0, 1'b0};
    tbl[4] = '{32'hFFFE_0000,  16'h0000, 1, 1'b0};
    tbl[5] = '{32'hFFFF_7FFF,  16'h7FFF, 2, 1'b1};
`endif

    // Reset state
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 0, 0);
    chk("rst.m_valid", 32'(m_valid), 0);
    chk("rst.level", 32'(level), 0);
    chk("rst.m_data", 32'(m_data), 0);
    chk("rst.m_row", 32'(m_row), 0);
    chk("rst.m_last", 32'(m_last), 0);
    chk("rst.flags", {30'd0, overflow, short_vec}, 0);

    // Basic + conversion table: one-cycle latency, rows 0,1,2 repeating
    step(0, 1, 0, '0, 1, 0);
    foreach (tbl[i]) begin
      step(0, 0, 1, tbl[i].y, 1, 0);
      chk("tbl.m_valid", 32'(m_valid), 1);
      chk("tbl.m_data", 32'(m_data), 32'(tbl[i].data));
      chk("tbl.m_row", 32'(m_row), 32'(tbl[i].row));
      chk("tbl.m_last", 32'(m_last), 32'(tbl[i].last));
      idle(1, 1);
      chk("tbl.drained", 32'(m_valid), 0);
      idle(1, 6);
    end

    // Backpressure: 4 rows fill, 5th dropped, then drain in order
    step(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 32'(10 + i), 0, 0);
      idle(0, 2);
      chk("bp.hold_data", 32'(m_data), 32'd10);
    end
    chk("bp.level4", 32'(level), 4);
    chk("bp.no_ovf", 32'(overflow), 0);
    step(0, 0, 1, 32'd99, 0, 0);
    chk("bp.ovf", 32'(overflow), 1);
    chk("bp.level_full", 32'(level), 4);
    for (int i = 0; i < 4; i++) begin
      chk("bp.order_row", 32'(m_row), 32'(i % NR));
      chk("bp.order_data", 32'(m_data), 32'(10 + i));
      step(0, 0, 0, '0, 1, 0);
    end
    chk("bp.empty", 32'(level), 0);
    step(0, 0, 0, '0, 1, 1);
    chk("bp.clr", 32'(overflow), 0);

    // Full with simultaneous pop: push accepted, level unchanged
    step(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'(20 + i), 0, 0);
    step(0, 0, 1, 32'd24, 1, 0);
    chk("fullpop.level", 32'(level), 4);
    chk("fullpop.ovf", 32'(overflow), 0);
    chk("fullpop.head", 32'(m_data), 21);
    idle(1, 4);
    chk("fullpop.tail", 32'(level), 0);

    // Short vector and clr_err
    step(0, 1, 0, '0, 1, 0);
    step(0, 0, 1, 32'd1, 1, 0);
    step(0, 0, 1, 32'd2, 1, 0);
    idle(1, 2);
    step(0, 1, 0, '0, 1, 0);
    chk("short.set", 32'(short_vec), 1);
    step(0, 0, 1, 32'd3, 1, 0);
    chk("short.row0", 32'(m_row), 0);
    step(0, 0, 0, '0, 1, 1);
    chk("short.clr", 32'(short_vec), 0);
    // start mid-vector with clr_err: set wins
    step(0, 1, 0, '0, 1, 1);
    chk("short.set_wins", 32'(short_vec), 1);
    step(0, 0, 0, '0, 1, 1);

    // Reset mid-operation
    step(0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'(40 + i), 0, 0);
    chk("rmid.level3", 32'(level), 3);
    step(1, 0, 0, '0, 0, 0);
    chk("rmid.valid", 32'(m_valid), 0);
    chk("rmid.level", 32'(level), 0);
    chk("rmid.flags", {30'd0, overflow, short_vec}, 0);
    step(0, 0, 1, 32'd7, 1, 0);
    chk("rmid.row0", 32'(m_row), 0);
    chk("rmid.data", 32'(m_data), 7);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] y;
      y = $urandom;
      if ($urandom_range(0, 1) == 1) y = AW'($signed(y) >>> 14);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 4, y, $urandom_range(0, 9) < 5,
           $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mvm_result_stage.md
# mvm_result_stage

Downstream stage of the matrix-vector multiplier controller. Captures each accumulated result row as the controller writes it to the y memory (wr_en_y pulse), converts it to the output data width, and queues it in a small FIFO. Rows leave over a valid/ready stream with a last marker on the final row of each vector. The controller runs ahead without waiting on the consumer; overflow is flagged, not back-pressured.

## Interface
- DATA_WIDTH, 16, width of streamed result word
- ACC_WIDTH, 32, width of signed accumulator value presented with wr_en_y
- NUM_ROWS, 3, rows per result vector (elements of y)
- FIFO_DEPTH, 4, queue entries, power of two, ≥2
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  controller start pulse; re-arms row counter for a new vector
- wr_en_y  in  1  one-cycle pulse: y_in valid for one row
- y_in  in  ACC_WIDTH  signed accumulator result (two's complement)
- m_valid  out  1  output word available
- m_ready  in  1  consumer accepts when m_valid & m_ready
- m_data  out  DATA_WIDTH  result row value
- m_row  out  $clog2(NUM_ROWS)  row index of m_data
- m_last  out  1  m_row == NUM_ROWS-1
- level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: a row was dropped due to full FIFO
- short_vec  out  1  sticky: start seen with partial vector captured
- clr_err  in  1  clears overflow and short_vec

## Operation
- Push: wr_en_y=1 writes {row_idx, conv(y_in)} at write pointer; row_idx then increments, wrapping NUM_ROWS-1 -> 0.
- Pop: m_valid & m_ready advances read pointer. m_valid = (level != 0). m_data/m_row/m_last show the head entry (show-ahead).
- Pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally; full when MSBs differ and lower bits equal; empty when equal.
- Full and wr_en_y with no pop that cycle: row dropped, overflow<=1, row_idx still increments (keeps alignment).
- Full and wr_en_y with pop same cycle: push accepted, level unchanged.
- Empty and wr_en_y: no pop possible that cycle (m_valid=0); level becomes 1.
- start=1: row_idx<=0; if row_idx was nonzero, short_vec<=1. start and wr_en_y same cycle: the pushed row gets index 0, row_idx<=1.
- clr_err=1 clears flags; a set event in the same cycle wins (flag stays 1).
- FIFO contents are not flushed by start; only reset flushes.
- conv(): see Configuration.

## Timing
- Reset (synchronous): pointers 0, level 0, row_idx 0, m_valid 0, m_data 0, m_row 0, m_last 0, overflow 0, short_vec 0. Reset mid-vector discards all queued rows; next row captured is row 0.
- Latency: wr_en_y in cycle N -> m_valid=1 with that data in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- m_data/m_row/m_last held stable while m_valid & !m_ready.
- level updates one cycle after the push/pop edge, registered.
- Controller spacing of wr_en_y is 8 cycles; FIFO_DEPTH 4 absorbs one full vector plus one row with m_ready stalled.

## Configuration
- MVM_RESULT_SAT_EN defined: conv() saturates y_in to signed DATA_WIDTH range: y_in > 2^(DATA_WIDTH-1)-1 -> 0x7FFF, y_in < -2^(DATA_WIDTH-1) -> 0x8000 (for DATA_WIDTH=16), else low DATA_WIDTH bits.
- Not defined: conv() = y_in[DATA_WIDTH-1:0] (wrap-around truncation), no comparators.

## Test plan
- Basic: m_ready=1, start, push y_in 5, -3, 100 eight cycles apart -> m_data 0x0005/0xFFFD/0x0064, m_row 0,1,2, m_last only on third, each one cycle after its push.
- Backpressure: m_ready=0, push 4 rows -> level 4, no overflow; 5th push -> dropped, overflow=1; then m_ready=1 -> 4 words out in order, m_row 0,1,2,0.
- Full with simultaneous pop: level 4, wr_en_y and m_ready same cycle -> level stays 4, overflow stays 0.
- Saturation: y_in 0x0001_0000 and 0xFFFE_0000 -> with MVM_RESULT_SAT_EN 0x7FFF/0x8000; without 0x0000/0x0000.
- Short vector: push 2 rows, then start -> short_vec=1; next push has m_row 0; clr_err -> short_vec=0.
- Reset mid-operation: level 3, reset one cycle -> m_valid 0, level 0, flags 0; next push emerges with m_row 0.
